// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the word PC to a synchronous-read ROM, re-aligns
// returned words with their PC and presents them to decode through IF/ID registers.
module fetch_unit #(
    parameter int            AW       = 10,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic          if_valid
);

    logic [AW-1:0] fetch_pc;
    logic          f2_valid;
    logic [AW-1:0] f2_pc;
    logic          skid_valid;
    logic [DW-1:0] skid_instr;
    logic [AW-1:0] skid_pc;

    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            f2_valid   <= 1'b0;
            f2_pc      <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_addr;
            f2_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else if (stall) begin
            // The ROM re-reads fetch_pc each stall cycle, so once the in-flight
            // word is parked in the skid the F2 tag can point at fetch_pc.
            // An empty in-flight slot stays empty, otherwise fetch_pc would be
            // tagged as in flight without having advanced and be delivered twice.
            if (f2_valid && !skid_valid) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_data;
                skid_pc    <= f2_pc;
            end
            if (f2_valid) begin
                f2_pc <= fetch_pc;
            end
        end else begin
            if (skid_valid) begin
                if_valid   <= 1'b1;
                if_instr   <= skid_instr;
                if_pc      <= skid_pc;
                skid_valid <= 1'b0;
            end else if (f2_valid) begin
                if_valid <= 1'b1;
                if_instr <= imem_data;
                if_pc    <= f2_pc;
            end else begin
                if_valid <= 1'b0;
                if_instr <= '0;
                if_pc    <= '0;
            end
            f2_valid <= 1'b1;
            f2_pc    <= fetch_pc;
            fetch_pc <= fetch_pc + 1'b1;
        end
    end

endmodule
